// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES S-box tables, SubBytes FSM encoding and ShiftRows source mapping

package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = a;
        for (int k = 1; k < 8; k++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] b);
        return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    endfunction

    // Tables are built at elaboration so forward and inverse always agree
    function automatic logic [255:0][7:0] gen_sbox(input logic inv);
        logic [255:0][7:0] t;
        for (int i = 0; i < 256; i++) begin
            t[i] = inv ? gf_inv(inv_affine(8'(i))) : affine(gf_inv(8'(i)));
        end
        return t;
    endfunction

    localparam logic [255:0][7:0] SBOX_FWD = gen_sbox(1'b0);
    localparam logic [255:0][7:0] SBOX_INV = gen_sbox(1'b1);

    // Source byte for destination d: row is kept, column shifts by row (mod 4)
    function automatic logic [3:0] src_byte(input logic [3:0] d, input logic inv);
        logic [1:0] r;
        logic [1:0] c;
        logic [1:0] cs;
        r  = d[1:0];
        c  = d[3:2];
        cs = inv ? (c - r) : (c + r);
        return {cs, r};
    endfunction

endpackage

// File: rtl/aes_sbox_rom.sv
// rtl/aes_sbox_rom.sv - dual-port registered S-box ROM with per-port forward/inverse select

module aes_sbox_rom
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       kill,
    input  logic [7:0] i_addr_a,
    input  logic       i_inv_a,
    input  logic [7:0] i_addr_b,
    input  logic       i_inv_b,
    output logic [7:0] o_data_a,
    output logic [7:0] o_data_b
);

    logic [7:0] r_data_a;
    logic [7:0] r_data_b;

    // Registered table reads; kill drops whatever was in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_a <= 8'h00;
            r_data_b <= 8'h00;
        end else if (kill) begin
            r_data_a <= 8'h00;
            r_data_b <= 8'h00;
        end else begin
            r_data_a <= i_inv_a ? SBOX_INV[i_addr_a] : SBOX_FWD[i_addr_a];
            r_data_b <= i_inv_b ? SBOX_INV[i_addr_b] : SBOX_FWD[i_addr_b];
        end
    end

    assign o_data_a = r_data_a;
    assign o_data_b = r_data_b;

endmodule

// File: rtl/aes_subbytes_lanes.sv
// rtl/aes_subbytes_lanes.sv - lane-parallel (Inv)SubBytes with optional fused (Inv)ShiftRows

module aes_subbytes_lanes
    import aes_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int SHIFT_ROWS = 1
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         kill,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_inv,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    localparam int NBEATS = 16 / LANES;
    localparam int NROMS  = (LANES + 1) / 2;
    localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(NBEATS - 1);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [CW-1:0]  r_cnt;
    logic [127:0]   r_src_data;
    logic           r_src_inv;
    logic           r_wr_en;
    logic [CW-1:0]  r_wr_beat;
    logic [127:0]   r_out_data;
    logic           w_accept;
    logic [7:0]     w_addr  [2*NROMS];
    logic [7:0]     w_rdata [2*NROMS];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state: kill wins, DONE may chain straight into a new RUN
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_nxt = ST_RUN;
            ST_RUN:   if (r_cnt == LAST_BEAT) w_state_nxt = ST_FLUSH;
            ST_FLUSH: w_state_nxt = ST_DONE;
            ST_DONE:  if (out_ready) w_state_nxt = w_accept ? ST_RUN : ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (kill) w_state_nxt = ST_IDLE;
    end

    // Handshake outputs decoded from state
    always_comb begin
        in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
        out_valid = (r_state == ST_DONE);
        w_accept  = in_valid && in_ready && !kill;
    end

    // Beat counter restarts on every accepted block
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                r_cnt <= '0;
        else if (kill || w_accept) r_cnt <= '0;
        else if (r_state == ST_RUN) r_cnt <= (r_cnt == LAST_BEAT) ? '0 : r_cnt + CW'(1);
    end

    // Source state and mode are frozen for the whole block
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src_data <= '0;
            r_src_inv  <= 1'b0;
        end else if (w_accept) begin
            r_src_data <= in_data;
            r_src_inv  <= in_inv;
        end
    end

    // Read addressing: lane j of beat k fills destination byte k*LANES+j
    for (genvar j = 0; j < 2*NROMS; j++) begin : g_lane
        if (j < LANES) begin : g_act
            logic [3:0] w_dst;
            logic [3:0] w_src;
            assign w_dst    = 4'(int'(r_cnt) * LANES + j);
            assign w_src    = (SHIFT_ROWS != 0) ? src_byte(w_dst, r_src_inv) : w_dst;
            assign w_addr[j] = r_src_data[{w_src, 3'b000} +: 8];
        end else begin : g_pad
            assign w_addr[j] = 8'h00;
        end
    end

    for (genvar p = 0; p < NROMS; p++) begin : g_rom
        aes_sbox_rom u_rom (
            .clk      (clk),
            .rst_n    (rst_n),
            .kill     (kill),
            .i_addr_a (w_addr[2*p]),
            .i_inv_a  (r_src_inv),
            .i_addr_b (w_addr[2*p+1]),
            .i_inv_b  (r_src_inv),
            .o_data_a (w_rdata[2*p]),
            .o_data_b (w_rdata[2*p+1])
        );
    end

    // Track which beat's ROM data arrives on the next edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en   <= 1'b0;
            r_wr_beat <= '0;
        end else if (kill) begin
            r_wr_en   <= 1'b0;
            r_wr_beat <= '0;
        end else begin
            r_wr_en   <= (r_state == ST_RUN);
            r_wr_beat <= r_cnt;
        end
    end

    // Write returned S-box bytes into their destination slots
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data <= '0;
        end else if (kill) begin
            r_out_data <= '0;
        end else if (r_wr_en) begin
            for (int j = 0; j < LANES; j++) begin
                r_out_data[(int'(r_wr_beat) * LANES + j) * 8 +: 8] <= w_rdata[j];
            end
        end
    end

    assign out_data = r_out_data;

endmodule

// File: doc/aes_subbytes_lanes.md
Name: aes_subbytes_lanes

Overview:
Parametrised SubBytes(+ShiftRows) engine for the AES datapath: takes a 128-bit state over a valid/ready handshake and returns SubBytes or InvSubBytes, optionally fused with ShiftRows/InvShiftRows. The state is processed LANES bytes per cycle through registered S-box ROMs, one read port per lane, mapped to BRAM. This trades area against throughput. Sits between AddRoundKey and MixColumns in the round datapath.

Parameters:
LANES, 4, bytes substituted per cycle; legal values 1, 2, 4, 8, 16; NBEATS = 16/LANES
SHIFT_ROWS, 1, 1 = fuse (Inv)ShiftRows into the read addressing, 0 = pure byte-wise substitution

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
kill  in  1  synchronous abort, highest priority after reset
in_valid  in  1  input state valid
in_ready  out  1  block can accept a state
in_inv  in  1  0 = forward S-box/ShiftRows, 1 = inverse; sampled with in_data
in_data  in  128  state; byte i = in_data[8i+7:8i], row r = i%4, column c = i/4
out_valid  out  1  result valid, held until accepted
out_ready  in  1  downstream accepts result
out_data  out  128  substituted state, same byte ordering

Behaviour:
- Reset (rst_n low, async): state IDLE, beat counter 0, out_valid 0, out_data 0, in_ready 1, internal state/mode registers 0.
- kill (sync): next edge -> IDLE, counter 0, out_valid 0, out_data 0; an in-flight ROM return is discarded. A kill asserted together with in_valid does not accept the input.
- Accept when in_valid & in_ready: latch in_data and in_inv into the source registers.
- FSM IDLE -> RUN on accept. RUN issues beat k = 0..NBEATS-1, one per cycle. After beat NBEATS-1 -> FLUSH (one cycle for ROM latency). FLUSH -> DONE with out_valid=1.
- Handshake:
  - DONE -> IDLE on out_ready.
  - in_ready = (IDLE) | (DONE & out_ready), so a new accept is allowed in the same cycle the result leaves. The FSM then goes DONE -> RUN directly.
- Latency: out_valid rises NBEATS+1 cycles after the accepting edge. LANES=16 gives 2 cycles; LANES=1 gives 17. Throughput is one block per NBEATS+2 cycles.
- Beat k, lane j writes destination byte d = k*LANES + j:
  - Forward (SHIFT_ROWS=1): source = byte at (row r, column (c+r) mod 4).
  - Inverse (SHIFT_ROWS=1): source = byte at (r, (c-r) mod 4).
  - SHIFT_ROWS=0: source = d.
- ROM read is registered: the address is issued in beat k, and data is written to out_data byte d on the next edge. out_data holds stale/partial bytes while out_valid=0; consumers use it only under out_valid.
- in_inv selects the forward/inverse table per block. Mode is constant within a block even if in_inv toggles mid-operation.
- out_valid & !out_ready: out_data held stable, in_ready 0, no new beats.
- Reset mid-operation: immediate async return to reset values; no partial output.

Decomposition:
- Package aes_pkg: SBOX_FWD and SBOX_INV 256x8 constant tables, state encoding (IDLE, RUN, FLUSH, DONE), byte-index helper function for the (Inv)ShiftRows source mapping.
- Sub-module aes_sbox_rom: dual-port, registered outputs, inv select per port, kill clears the output registers. Instantiate ceil(LANES/2) times.

Test Plan:
- LANES=16, SHIFT_ROWS=0, in_data=0, in_inv=0 -> out_valid 2 cycles after accept; out_data = 128'h63 repeated in all 16 bytes.
- LANES=4, SHIFT_ROWS=1, fwd, FIPS-197 App. B round-1 start state bytes 0..15 = 19 3d e3 be a0 f4 e2 2b 9a c6 8d 2a e9 f8 48 08 -> out bytes 0..15 = d4 bf 5d 30 e0 b4 52 ae b8 41 11 f1 1e 27 98 e5; out_valid exactly 5 cycles after accept.
- LANES=1, SHIFT_ROWS=1, inv, input = the expected output of the previous test -> out bytes 19 3d e3 be a0 f4 e2 2b 9a c6 8d 2a e9 f8 48 08 after 17 cycles.
- Back-to-back, LANES=8: out_ready tied 1, in_valid held 1 with two blocks -> second accept in the same cycle the first result is consumed; first result held while out_ready is pulsed low for 3 cycles.
- kill asserted in RUN beat 1, then rst_n pulsed low mid-FLUSH -> out_valid never rises; out_data=0; in_ready=1 next cycle; a subsequent block (all bytes 8'h53) yields all bytes 8'hed.
- in_inv toggled every cycle during RUN (LANES=2) -> result matches the mode latched at accept only.
